// File: rtl/prbs_checker.sv
// Receive-side checker for an x^15 + x + 1 PRBS stream: self-synchronises,
// confirms lock over VERIFY_LEN predictions, then counts and windows bit errors.
//
// state  | meaning
// SEARCH | shifting raw input bits into the lfsr until 15 are collected
// VERIFY | lfsr free-runs; input must match the prediction VERIFY_LEN times
// LOCKED | lfsr flywheels on its own prediction; mismatches are counted
module prbs_checker #(
  parameter int ERR_W      = 16,
  parameter int VERIFY_LEN = 15,
  parameter int WIN_LEN    = 64,
  parameter int LOSS_ERRS  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int VW = 8;
  localparam int WW = 10;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [14:0]      lfsr, lfsr_nxt;
  logic [3:0]       fill_cnt, fill_nxt;
  logic [VW-1:0]    verify_cnt, verify_nxt;
  logic [WW-1:0]    win_cnt, win_nxt;
  logic [WW-1:0]    win_errs, win_errs_nxt, errs_now;
  logic [ERR_W-1:0] err_cnt_nxt;
  logic             err_pulse_nxt, lock_lost_nxt;
  logic             pred, mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= SEARCH;
      lfsr       <= '0;
      fill_cnt   <= '0;
      verify_cnt <= '0;
      win_cnt    <= '0;
      win_errs   <= '0;
      err_cnt    <= '0;
      err_pulse  <= 1'b0;
      lock_lost  <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state      <= state_nxt;
      lfsr       <= lfsr_nxt;
      fill_cnt   <= fill_nxt;
      verify_cnt <= verify_nxt;
      win_cnt    <= win_nxt;
      win_errs   <= win_errs_nxt;
      err_cnt    <= err_cnt_nxt;
      err_pulse  <= err_pulse_nxt;
      lock_lost  <= lock_lost_nxt;
      locked     <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt     = state;
    lfsr_nxt      = lfsr;
    fill_nxt      = fill_cnt;
    verify_nxt    = verify_cnt;
    win_nxt       = win_cnt;
    win_errs_nxt  = win_errs;
    err_cnt_nxt   = err_cnt;
    err_pulse_nxt = 1'b0;
    lock_lost_nxt = 1'b0;
    pred          = lfsr[1] ^ lfsr[0];
    mismatch      = din ^ pred;
    errs_now      = win_errs + WW'(mismatch);

    if (din_valid) begin
      case (state)
        SEARCH: begin
          lfsr_nxt = {din, lfsr[14:1]};
          if (fill_cnt == 4'd14) begin
            fill_nxt = '0;
            // an all-zero fill is the LFSR lockup state and can never verify
            if (lfsr_nxt != '0) begin
              state_nxt  = VERIFY;
              verify_nxt = '0;
            end
          end else begin
            fill_nxt = fill_cnt + 4'd1;
          end
        end
        VERIFY: begin
          lfsr_nxt = {pred, lfsr[14:1]};
          if (!mismatch) begin
            if (verify_cnt == VW'(VERIFY_LEN - 1)) begin
              state_nxt    = LOCKED;
              win_nxt      = '0;
              win_errs_nxt = '0;
            end else begin
              verify_nxt = verify_cnt + VW'(1);
            end
          end else begin
            state_nxt = SEARCH;
            fill_nxt  = '0;
          end
        end
        LOCKED: begin
          lfsr_nxt = {pred, lfsr[14:1]};
          if (mismatch) begin
            err_pulse_nxt = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_W'(1);
          end
          // loss takes precedence over a window wrap on the same bit
          if (mismatch && (errs_now == WW'(LOSS_ERRS))) begin
            state_nxt     = SEARCH;
            fill_nxt      = '0;
            lock_lost_nxt = 1'b1;
          end else if (win_cnt == WW'(WIN_LEN - 1)) begin
            win_nxt      = '0;
            win_errs_nxt = '0;
          end else begin
            win_nxt      = win_cnt + WW'(1);
            win_errs_nxt = errs_now;
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end

    if (clr_cnt) err_cnt_nxt = '0;
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Self-checking bench for prbs_checker: a PRBS source feeds the checker with
// random gaps and injected bit errors, compared against a queue-based model.
module tb_prbs_checker;

  localparam int VLEN = 15;
  localparam int WIN  = 64;
  localparam int LOSS = 8;
  localparam int MAXC = 65535;

  logic        clk = 1'b0;
  logic        rst, din, din_valid, clr_cnt;
  logic        locked, err_pulse, lock_lost;
  logic [15:0] err_cnt;
  logic        locked2, err_pulse2, lock_lost2;
  logic [3:0]  err_cnt2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .lock_lost(lock_lost), .err_cnt(err_cnt)
  );

  prbs_checker #(.ERR_W(4), .VERIFY_LEN(15), .WIN_LEN(64), .LOSS_ERRS(64)) dut_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_cnt(clr_cnt),
    .locked(locked2), .err_pulse(err_pulse2), .lock_lost(lock_lost2), .err_cnt(err_cnt2)
  );

  // ---------------- PRBS source ----------------
  logic [14:0] seed_v = 15'b100101010000000;
  bit g_hist[$];
  int g_idx;

  function automatic void gen_restart();
    g_hist.delete();
    g_idx = 0;
  endfunction

  // s[n] = s[n-15] ^ s[n-14], first 15 bits taken from the seed LSB first
  function automatic bit gen_next();
    bit b;
    if (g_idx < 15) b = seed_v[g_idx];
    else            b = g_hist[0] ^ g_hist[1];
    g_hist.push_back(b);
    if (g_hist.size() > 15) void'(g_hist.pop_front());
    g_idx++;
    return b;
  endfunction

  // ---------------- reference model ----------------
  int m_mode;  // 0 hunting, 1 confirming, 2 locked
  bit m_hist[$];
  int m_fill, m_ver, m_win, m_werr, m_cnt;
  bit m_locked, m_pulse, m_lost;

  function automatic void model_reset();
    m_mode = 0;
    m_hist.delete();
    repeat (15) m_hist.push_back(1'b0);
    m_fill = 0; m_ver = 0; m_win = 0; m_werr = 0; m_cnt = 0;
    m_locked = 0; m_pulse = 0; m_lost = 0;
  endfunction

  function automatic void model_step(bit d, bit v, bit c);
    bit p, any;
    m_pulse = 0;
    m_lost  = 0;
    if (v) begin
      p = m_hist[0] ^ m_hist[1];
      if (m_mode == 0) begin
        m_hist.push_back(d);
        void'(m_hist.pop_front());
        m_fill++;
        if (m_fill == 15) begin
          m_fill = 0;
          any = 0;
          foreach (m_hist[i]) any |= m_hist[i];
          if (any) begin m_mode = 1; m_ver = 0; end
        end
      end else begin
        m_hist.push_back(p);
        void'(m_hist.pop_front());
        if (m_mode == 1) begin
          if (d == p) begin
            m_ver++;
            if (m_ver == VLEN) begin m_mode = 2; m_win = 0; m_werr = 0; end
          end else begin
            m_mode = 0; m_fill = 0;
          end
        end else begin
          if (d != p) begin
            m_pulse = 1;
            if (m_cnt < MAXC) m_cnt++;
            m_werr++;
          end
          if (d != p && m_werr == LOSS) begin
            m_mode = 0; m_fill = 0; m_lost = 1;
          end else begin
            m_win++;
            if (m_win == WIN) begin m_win = 0; m_werr = 0; end
          end
        end
      end
    end
    if (c) m_cnt = 0;
    m_locked = (m_mode == 2);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit d, input bit v, input bit c);
    din = d; din_valid = v; clr_cnt = c;
    @(posedge clk);
    model_step(d, v, c);
    #1;
  endtask

  task automatic do_reset();
    din_valid = 0; clr_cnt = 0; din = 0;
    rst = 0;
    @(posedge clk);
    #1;
    rst = 1;
    model_reset();
    gen_restart();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 0; din = 0; din_valid = 0; clr_cnt = 0;
    #12;
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || lock_lost !== 1'b0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_outputs got l=%b p=%b ll=%b cnt=%0d want all 0", locked, err_pulse, lock_lost, err_cnt);
    end
    checks++;
    if (locked2 !== 1'b0 || err_cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL reset_sat_outputs got l=%b cnt=%0d want 0", locked2, err_cnt2);
    end
    rst = 1;
    model_reset();
    gen_restart();
  endtask

  task automatic test_clean_lock();
    do_reset();
    for (int n = 1; n <= 2000; n++) begin
      drive(gen_next(), 1'b1, 1'b0);
      checks++;
      if (locked !== (n >= 30)) begin
        failures++;
        $display("FAIL clean_lock n=%0d locked=%b want %b", n, locked, (n >= 30));
      end
      checks++;
      if (err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL clean_err_pulse n=%0d got %b want 0", n, err_pulse);
      end
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL clean_err_cnt got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_gaps();
    int n = 0;
    do_reset();
    while (n < 200) begin
      drive(gen_next(), 1'b1, 1'b0);
      n++;
      checks++;
      if (locked !== (n >= 30) || err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL gaps_valid n=%0d locked=%b pulse=%b want %b 0", n, locked, err_pulse, (n >= 30));
      end
      repeat ($urandom_range(0, 2)) begin
        drive(1'($urandom), 1'b0, 1'b0);
        checks++;
        if (locked !== (n >= 30) || err_pulse !== 1'b0) begin
          failures++;
          $display("FAIL gaps_idle n=%0d locked=%b pulse=%b want %b 0", n, locked, err_pulse, (n >= 30));
        end
      end
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL gaps_err_cnt got %0d want 0", err_cnt);
    end
  endtask

  task automatic test_single_error();
    bit b;
    do_reset();
    for (int n = 1; n <= 160; n++) begin
      b = gen_next();
      if (n == 100) b = ~b;
      drive(b, 1'b1, 1'b0);
      if (n == 100) begin
        checks++;
        if (err_pulse !== 1'b1 || err_cnt !== 16'd1 || locked !== 1'b1) begin
          failures++;
          $display("FAIL single_err_hit pulse=%b cnt=%0d locked=%b want 1 1 1", err_pulse, err_cnt, locked);
        end
      end else if (n > 100) begin
        checks++;
        if (err_pulse !== 1'b0 || err_cnt !== 16'd1 || locked !== 1'b1) begin
          failures++;
          $display("FAIL single_err_after n=%0d pulse=%b cnt=%0d locked=%b want 0 1 1", n, err_pulse, err_cnt, locked);
        end
      end
    end
  endtask

  task automatic test_loss();
    bit flip[int];
    int last = 0, lost_seen = 0, p;
    bit b;
    do_reset();
    while (flip.num() < 8) begin
      p = $urandom_range(41, 94);
      flip[p] = 1;
      if (p > last) last = p;
    end
    for (int n = 1; n <= last + 40; n++) begin
      b = gen_next();
      if (flip.exists(n)) b = ~b;
      drive(b, 1'b1, 1'b0);
      if (lock_lost === 1'b1) lost_seen++;
      checks++;
      if (locked !== m_locked || err_pulse !== m_pulse || lock_lost !== m_lost || err_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL loss_model n=%0d got l=%b p=%b ll=%b c=%0d want %b %b %b %0d",
                 n, locked, err_pulse, lock_lost, err_cnt, m_locked, m_pulse, m_lost, m_cnt);
      end
      if (n == last) begin
        checks++;
        if (lock_lost !== 1'b1 || locked !== 1'b0 || err_cnt !== 16'd8) begin
          failures++;
          $display("FAIL loss_event ll=%b locked=%b cnt=%0d want 1 0 8", lock_lost, locked, err_cnt);
        end
      end
      if (n == last + 29 || n == last + 30) begin
        checks++;
        if (locked !== (n == last + 30)) begin
          failures++;
          $display("FAIL relock n=%0d locked=%b want %b", n - last, locked, (n == last + 30));
        end
      end
    end
    checks++;
    if (lost_seen != 1) begin
      failures++;
      $display("FAIL loss_pulse_count got %0d want 1", lost_seen);
    end
  endtask

  task automatic test_all_zero();
    do_reset();
    for (int n = 1; n <= 200; n++) begin
      drive(1'b0, 1'b1, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
        failures++;
        $display("FAIL all_zero n=%0d locked=%b want 0", n, locked);
      end
    end
  endtask

  task automatic test_verify_flip();
    bit b;
    do_reset();
    for (int n = 1; n <= 70; n++) begin
      b = gen_next();
      if (n == 20) b = ~b;
      drive(b, 1'b1, 1'b0);
      checks++;
      if (locked !== (n >= 50) || err_pulse !== 1'b0) begin
        failures++;
        $display("FAIL verify_flip n=%0d locked=%b pulse=%b want %b 0", n, locked, err_pulse, (n >= 50));
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 1; n <= 30; n++) drive(gen_next(), 1'b1, 1'b0);
    checks++;
    if (locked2 !== 1'b1) begin
      failures++;
      $display("FAIL sat_lock locked=%b want 1", locked2);
    end
    for (int k = 1; k <= 40; k++) begin
      drive(~gen_next(), 1'b1, 1'b0);
      checks++;
      if (err_cnt2 !== 4'((k < 15) ? k : 15) || locked2 !== 1'b1 || err_pulse2 !== 1'b1) begin
        failures++;
        $display("FAIL saturate k=%0d cnt=%0d locked=%b pulse=%b want %0d 1 1",
                 k, err_cnt2, locked2, err_pulse2, (k < 15) ? k : 15);
      end
    end
  endtask

  task automatic test_clr();
    bit b;
    do_reset();
    for (int n = 1; n <= 40; n++) drive(gen_next(), 1'b1, 1'b0);
    drive(~gen_next(), 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL clr_pre cnt=%0d want 1", err_cnt);
    end
    repeat (3) drive(gen_next(), 1'b1, 1'b0);
    drive(~gen_next(), 1'b1, 1'b1);
    checks++;
    if (err_cnt !== 16'd0 || err_pulse !== 1'b1 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clr_coincident cnt=%0d pulse=%b locked=%b want 0 1 1", err_cnt, err_pulse, locked);
    end
    drive(~gen_next(), 1'b1, 1'b0);
    checks++;
    if (err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL clr_recount cnt=%0d want 1", err_cnt);
    end
    b = 1'($urandom);
    drive(b, 1'b0, 1'b1);
    checks++;
    if (err_cnt !== 16'd0 || locked !== 1'b1) begin
      failures++;
      $display("FAIL clr_idle cnt=%0d locked=%b want 0 1", err_cnt, locked);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 1; n <= 39; n++) drive(gen_next(), 1'b1, 1'b0);
    drive(~gen_next(), 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_pulse !== 1'b1 || err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL async_pre locked=%b pulse=%b cnt=%0d want 1 1 1", locked, err_pulse, err_cnt);
    end
    din_valid = 0;
    #2 rst = 0;
    #1;
    checks++;
    if (locked !== 1'b0 || err_pulse !== 1'b0 || lock_lost !== 1'b0 || err_cnt !== 16'd0 ||
        locked2 !== 1'b0 || err_cnt2 !== 4'd0) begin
      failures++;
      $display("FAIL async_reset l=%b p=%b ll=%b c=%0d l2=%b c2=%0d want all 0",
               locked, err_pulse, lock_lost, err_cnt, locked2, err_cnt2);
    end
    @(posedge clk);
    #1 rst = 1;
    model_reset();
    gen_restart();
  endtask

  task automatic test_random_soak();
    bit v, c, b;
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 199) == 0);
      if (v) begin
        b = gen_next();
        if (((cyc / 500) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 79) == 0)) b = ~b;
      end else begin
        b = 1'($urandom);
      end
      drive(b, v, c);
      checks++;
      if (locked !== m_locked || err_pulse !== m_pulse || lock_lost !== m_lost || err_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL soak cyc=%0d got l=%b p=%b ll=%b c=%0d want %b %b %b %0d",
                 cyc, locked, err_pulse, lock_lost, err_cnt, m_locked, m_pulse, m_lost, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_gaps();
    test_single_error();
    test_loss();
    test_all_zero();
    test_verify_flip();
    test_saturation();
    test_clr();
    test_async_reset();
    test_random_soak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
Name: prbs_checker

Overview:
- Receive-end checker for the serial PRBS stream produced by the game's pseudo-random source (x^15 + x + 1 LFSR, DVB-T style).
- Self-synchronises to the incoming bit stream, confirms the lock, then counts bit errors.
- Drops lock when errors are excessive, then re-acquires automatically.
- Used on the debug/verification path to prove the random piece source is healthy.

Parameters:
- ERR_W, 16, width of the saturating error counter.
- VERIFY_LEN, 15, consecutive correct predictions required after fill before declaring lock (1..255).
- WIN_LEN, 64, length of the loss-detection window in valid bits (2..1023).
- LOSS_ERRS, 8, mismatches within one window that force loss of lock (1..WIN_LEN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- din  input  1  received PRBS bit.
- din_valid  input  1  din is valid this cycle; one bit consumed per valid cycle; gaps allowed.
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  high while in LOCKED state.
- err_pulse  output  1  one-cycle pulse per counted mismatch.
- lock_lost  output  1  one-cycle pulse on the LOCKED -> SEARCH transition.
- err_cnt  output  ERR_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset (rst low, async): state SEARCH, lfsr = 0, fill/verify/window counters = 0.
- Reset values of outputs: locked = 0, err_pulse = 0, lock_lost = 0, err_cnt = 0.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- LFSR convention: 15-bit lfsr, bit 0 oldest.
  - Prediction pred = lfsr[1] ^ lfsr[0].
  - Shift = {newbit, lfsr[14:1]}.
- Cycles with din_valid = 0: no state, counter or lfsr change; err_pulse = 0, lock_lost = 0.
- SEARCH:
  - Each valid bit: lfsr <= {din, lfsr[14:1]}; fill_cnt increments.
  - On the 15th bit, test the resulting lfsr.
  - If it is nonzero: go to VERIFY, verify_cnt = 0.
  - If it is all-zero: stay in SEARCH, fill_cnt = 0 (the all-zero lockup state is never accepted).
- VERIFY:
  - Each valid bit: lfsr <= {pred, lfsr[14:1]}.
  - If din == pred: verify_cnt++. When the count reaches VERIFY_LEN, go to LOCKED with win_cnt = 0 and win_errs = 0.
  - If din != pred: go to SEARCH, fill_cnt = 0; the offending bit is discarded.
  - Mismatches in VERIFY are not counted and produce no err_pulse.
- LOCKED:
  - Each valid bit: lfsr <= {pred, lfsr[14:1]}, flywheel on the prediction, never on din.
  - Mismatch: err_pulse = 1 next cycle; err_cnt++ (saturates at all-ones); win_errs++.
  - If win_errs including the current bit reaches LOSS_ERRS: go to SEARCH, fill_cnt = 0, lock_lost = 1 next cycle; locked falls the same edge.
  - Window: win_cnt counts valid bits 0..WIN_LEN-1. The bit at WIN_LEN-1 is evaluated in the ending window, then win_cnt and win_errs reset to 0.
  - If loss and window wrap occur on the same bit, loss wins.
- Output registration: all outputs are registered; locked = (state == LOCKED) as a register.
- Lock timing on a clean stream: locked rises on the clock edge that consumes valid bit 15 + VERIFY_LEN (bit 30 with defaults).
- clr_cnt: err_cnt <= 0 on the next edge and has priority over a simultaneous increment (result 0). clr_cnt does not affect lock state or window counters.
- err_cnt is retained across loss of lock; only rst or clr_cnt clear it.

Test Plan:
- Clean stream from seed 15'b100101010000000, din_valid continuous:
  - locked = 1 exactly after the 30th valid bit.
  - err_cnt stays 0 over 2000 bits; err_pulse never asserted.
- Same stream with din_valid toggling 1-0-0 (random gaps): lock after the 30th valid bit, independent of gaps; no errors.
- Locked, invert one bit at position 100: err_pulse high for exactly one cycle, err_cnt = 1, locked stays 1, later bits match (flywheel did not absorb the error).
- Locked, invert 8 bits within one 64-bit window:
  - lock_lost pulses once on the 8th error; locked = 0; err_cnt = 8.
  - Re-lock after 30 further clean bits.
- All-zero input for 200 valid bits: locked never asserts.
- Bit flip during VERIFY (bit 20): returns to SEARCH, no err_pulse; lock occurs 30 bits after the flip.
- Error counter and reset:
  - ERR_W = 4 with continuous inverted input after lock and LOSS_ERRS = WIN_LEN: err_cnt saturates at 15.
  - clr_cnt coincident with an error yields 0.
  - rst pulsed low mid-lock, asynchronously between edges: all outputs 0 immediately.
